// File: rtl/eth_tx_pkt_gen.sv
// ---------------------------------------------------------------------------
// eth_tx_pkt_gen
//   Avalon-ST packet source for the 10G MAC transmit client interface
//   (32-bit beats, readyLatency 0). Emits runs of Ethernet frames (no FCS)
//   carrying a 16-bit sequence number and a per-packet payload counter,
//   for loopback and end-to-end link testing.
//
// Handshake: a beat transfers on a rising edge where valid && ready. Once
//   valid is raised it stays high, and data/sop/eop/empty/error stay
//   unchanged, until that beat transfers.
//
// Ports
//   tx_156_25_clk        block clock
//   tx_rst_n             synchronous active-low reset
//   start                one-cycle pulse: latch configuration, begin a run
//   stop                 level: finish the current packet, then end the run
//   num_pkts             packets per run (0 = continuous until stop)
//   pkt_len              frame length in bytes, excluding FCS
//   dst_mac / src_mac    MAC addresses placed in the header
//   err_inject           sampled at SOP; flags that packet's EOP beat
//   busy / done          run in progress / one-cycle end-of-run pulse
//   pkts_sent            packets whose EOP beat was accepted in this run
//   avalon_st_tx_*       Avalon-ST source towards the MAC
// ---------------------------------------------------------------------------
module eth_tx_pkt_gen #(
  parameter int          IPG_CYCLES = 4,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int          MIN_LEN    = 60,
  parameter int          MAX_LEN    = 9600
) (
  input  logic        tx_156_25_clk,
  input  logic        tx_rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] num_pkts,
  input  logic [13:0] pkt_len,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic        err_inject,
  output logic        busy,
  output logic        done,
  output logic [31:0] pkts_sent,
  output logic        avalon_st_tx_valid,
  output logic [31:0] avalon_st_tx_data,
  output logic        avalon_st_tx_startofpacket,
  output logic        avalon_st_tx_endofpacket,
  output logic [1:0]  avalon_st_tx_empty,
  output logic        avalon_st_tx_error,
  input  logic        avalon_st_tx_ready
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // FSM state is kept as a named signal so checkers can bind to it.
  state_t state, state_d;

  // Latched run configuration
  logic [13:0] words_q;
  logic [1:0]  empty_cfg_q;
  logic [15:0] num_q;
  logic [47:0] dst_q, src_q;

  // Run / packet bookkeeping
  logic [13:0] idx_q, idx_d;     // index of the word currently on the bus
  logic [15:0] gap_q, gap_d;
  logic [15:0] seq_q;
  logic [31:0] pkts_q;
  logic        err_q;            // err_inject captured at the SOP transfer

  // Registered outputs and their next values
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [1:0]  empty_q, empty_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Configuration derived from the inputs at start time
  logic [13:0] len_clamped;
  logic [13:0] start_words;
  logic [1:0]  start_empty;

  always_comb begin
    if (pkt_len < 14'(MIN_LEN))      len_clamped = 14'(MIN_LEN);
    else if (pkt_len > 14'(MAX_LEN)) len_clamped = 14'(MAX_LEN);
    else                             len_clamped = pkt_len;
    start_words = (len_clamped + 14'd3) >> 2;
    // (4 - len mod 4) mod 4 is simply the 2-bit negation of len[1:0]
    start_empty = 2'd0 - len_clamped[1:0];
  end

  // Word n of a frame. On a partial final beat the word is moved up into
  // the valid (most significant) byte lanes so the unused lanes carry 0.
  function automatic logic [31:0] word_at(input logic [13:0] n,
                                          input logic        last,
                                          input logic [1:0]  emp,
                                          input logic [47:0] dst,
                                          input logic [47:0] src,
                                          input logic [15:0] seq);
    logic [31:0] w;
    case (n)
      14'd0:   w = dst[47:16];
      14'd1:   w = {dst[15:0], src[47:32]};
      14'd2:   w = src[31:0];
      14'd3:   w = {ETHERTYPE, seq};
      default: w = 32'(n - 14'd4);
    endcase
    if (last) w = w << {emp, 3'b000};
    return w;
  endfunction

  logic        xfer, last_pkt, err_now, cfg_load, do_load;
  logic [13:0] ld_n, ld_words;
  logic [15:0] ld_seq;
  logic [1:0]  ld_empty;
  logic [47:0] ld_dst, ld_src;
  logic        ld_last;

  always_comb begin
    xfer     = valid_q && avalon_st_tx_ready;
    last_pkt = stop || ((num_q != 16'd0) && ((pkts_q + 32'd1) == {16'd0, num_q}));
    err_now  = (xfer && sop_q) ? err_inject : err_q;

    state_d  = state;
    valid_d  = valid_q;
    data_d   = data_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    empty_d  = empty_q;
    error_d  = error_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    idx_d    = idx_q;
    gap_d    = gap_q;
    cfg_load = 1'b0;
    do_load  = 1'b0;
    ld_n     = 14'd0;
    ld_seq   = seq_q;

    case (state)
      IDLE: begin
        if (start) begin
          cfg_load = 1'b1;
          busy_d   = 1'b1;
          state_d  = SEND;
          do_load  = 1'b1;
        end
      end
      SEND: begin
        if (xfer) begin
          if (eop_q) begin
            if (last_pkt) begin
              state_d = IDLE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              valid_d = 1'b0;
            end else if (IPG_CYCLES == 0) begin
              // back-to-back: next SOP already carries the incremented seq
              do_load = 1'b1;
              ld_seq  = seq_q + 16'd1;
            end else begin
              state_d = GAP;
              gap_d   = 16'd0;
              valid_d = 1'b0;
            end
          end else begin
            do_load = 1'b1;
            ld_n    = idx_q + 14'd1;
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (gap_q == 16'(IPG_CYCLES - 1)) begin
          state_d = SEND;
          do_load = 1'b1;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    ld_words = cfg_load ? start_words : words_q;
    ld_empty = cfg_load ? start_empty : empty_cfg_q;
    ld_dst   = cfg_load ? dst_mac     : dst_q;
    ld_src   = cfg_load ? src_mac     : src_q;
    ld_last  = (ld_n == ld_words - 14'd1);

    if (do_load) begin
      valid_d = 1'b1;
      data_d  = word_at(ld_n, ld_last, ld_empty, ld_dst, ld_src, ld_seq);
      sop_d   = (ld_n == 14'd0);
      eop_d   = ld_last;
      empty_d = ld_last ? ld_empty : 2'd0;
      error_d = ld_last ? err_now  : 1'b0;
      idx_d   = ld_n;
    end else if (!valid_d) begin
      data_d  = 32'd0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      empty_d = 2'd0;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge tx_156_25_clk) begin
    if (!tx_rst_n) begin
      state       <= IDLE;
      words_q     <= 14'd0;
      empty_cfg_q <= 2'd0;
      num_q       <= 16'd0;
      dst_q       <= 48'd0;
      src_q       <= 48'd0;
      idx_q       <= 14'd0;
      gap_q       <= 16'd0;
      seq_q       <= 16'd0;
      pkts_q      <= 32'd0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= 32'd0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      empty_q     <= 2'd0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state   <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      empty_q <= empty_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (cfg_load) begin
        words_q     <= start_words;
        empty_cfg_q <= start_empty;
        num_q       <= num_pkts;
        dst_q       <= dst_mac;
        src_q       <= src_mac;
        pkts_q      <= 32'd0;
      end
      if (xfer && eop_q) begin
        pkts_q <= pkts_q + 32'd1;
        seq_q  <= seq_q + 16'd1;
      end
      if (xfer && sop_q) err_q <= err_inject;
    end
  end

  assign busy                       = busy_q;
  assign done                       = done_q;
  assign pkts_sent                  = pkts_q;
  assign avalon_st_tx_valid         = valid_q;
  assign avalon_st_tx_data          = data_q;
  assign avalon_st_tx_startofpacket = sop_q;
  assign avalon_st_tx_endofpacket   = eop_q;
  assign avalon_st_tx_empty         = empty_q;
  assign avalon_st_tx_error         = error_q;

endmodule
